// File: rtl/sd_sector_arbiter.sv
// rtl/sd_sector_arbiter.sv - round-robin sector arbiter sharing one SD controller
// Grants one client per 512-byte sector; routes strobed bytes between client and controller.
module sd_sector_arbiter #(
    parameter int NUM_CLIENTS  = 3,
    parameter int SECTOR_BYTES = 512,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            req,
    input  logic [NUM_CLIENTS-1:0]            req_wr,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_CLIENTS-1:0]            grant,
    output logic [NUM_CLIENTS-1:0]            done,
    output logic                              busy,
    output logic                              rd_byte_valid,
    output logic [7:0]                        rd_byte,
    output logic                              wr_byte_req,
    input  logic [7:0]                        wr_byte,
    input  logic                              sd_ready,
    output logic                              sd_rd,
    output logic                              sd_wr,
    output logic [ADDR_WIDTH-1:0]             sd_addr,
    input  logic [7:0]                        sd_dout,
    input  logic                              sd_byte_available,
    output logic [7:0]                        sd_din,
    input  logic                              sd_ready_for_next_byte
);
    localparam int CW = $clog2(SECTOR_BYTES);
    localparam int IW = $clog2(NUM_CLIENTS);
    localparam logic [CW-1:0]         CNT_LAST  = CW'(SECTOR_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(SECTOR_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [NUM_CLIENTS-1:0]  grant_q, grant_d;
    logic                    dir_wr_q, dir_wr_d;
    logic [ADDR_WIDTH-1:0]   sd_addr_q, sd_addr_d;
    logic                    sd_rd_q, sd_rd_d;
    logic                    sd_wr_q, sd_wr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           rr_q, rr_d;
    logic                    avail_prev_q, avail_prev_d;
    logic                    rdy_prev_q, rdy_prev_d;
    logic                    rd_byte_valid_q, rd_byte_valid_d;
    logic [7:0]              rd_byte_q, rd_byte_d;

    logic [IW-1:0]           cand;
    logic [IW-1:0]           pick;
    logic                    found;
    logic [NUM_CLIENTS-1:0]  pick_onehot;
    logic [ADDR_WIDTH-1:0]   pick_addr;
    logic                    pick_wr;
    logic                    strobe_edge;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (int'(v) >= NUM_CLIENTS - 1) ? '0 : v + 1'b1;
    endfunction

    // Search starts at the round-robin pointer so the last winner goes to the back.
    always_comb begin
        cand        = rr_q;
        pick        = '0;
        found       = 1'b0;
        pick_onehot = '0;
        pick_addr   = '0;
        pick_wr     = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = wrap_inc(cand);
        end
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (IW'(i) == pick) begin
                pick_onehot[i] = 1'b1;
                pick_addr      = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                pick_wr        = req_wr[i];
            end
        end
    end

    // Only the strobe of the granted direction is watched; a held level counts once.
    assign strobe_edge = dir_wr_q ? (sd_ready_for_next_byte & ~rdy_prev_q)
                                  : (sd_byte_available & ~avail_prev_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            grant_q         <= '0;
            dir_wr_q        <= 1'b0;
            sd_addr_q       <= '0;
            sd_rd_q         <= 1'b0;
            sd_wr_q         <= 1'b0;
            cnt_q           <= '0;
            rr_q            <= '0;
            avail_prev_q    <= 1'b0;
            rdy_prev_q      <= 1'b0;
            rd_byte_valid_q <= 1'b0;
            rd_byte_q       <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            dir_wr_q        <= dir_wr_d;
            sd_addr_q       <= sd_addr_d;
            sd_rd_q         <= sd_rd_d;
            sd_wr_q         <= sd_wr_d;
            cnt_q           <= cnt_d;
            rr_q            <= rr_d;
            avail_prev_q    <= avail_prev_d;
            rdy_prev_q      <= rdy_prev_d;
            rd_byte_valid_q <= rd_byte_valid_d;
            rd_byte_q       <= rd_byte_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        dir_wr_d        = dir_wr_q;
        sd_addr_d       = sd_addr_q;
        sd_rd_d         = sd_rd_q;
        sd_wr_d         = sd_wr_q;
        cnt_d           = cnt_q;
        rr_d            = rr_q;
        avail_prev_d    = sd_byte_available;
        rdy_prev_d      = sd_ready_for_next_byte;
        rd_byte_valid_d = 1'b0;
        rd_byte_d       = rd_byte_q;
        case (state_q)
            S_IDLE: begin
                if (found && sd_ready) begin
                    state_d   = S_XFER;
                    grant_d   = pick_onehot;
                    dir_wr_d  = pick_wr;
                    sd_addr_d = pick_addr & ADDR_MASK;
                    sd_rd_d   = ~pick_wr;
                    sd_wr_d   = pick_wr;
                    cnt_d     = '0;
                    rr_d      = wrap_inc(pick);
                end
            end
            S_XFER: begin
                if (strobe_edge) begin
                    if (!dir_wr_q) begin
                        rd_byte_valid_d = 1'b1;
                        rd_byte_d       = sd_dout;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        sd_rd_d = 1'b0;
                        sd_wr_d = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE) ? grant_q : '0;
        wr_byte_req = (state_q == S_XFER) && dir_wr_q && strobe_edge;
        sd_din      = (|grant_q && dir_wr_q) ? wr_byte : 8'h00;
    end

    assign grant         = grant_q;
    assign sd_rd         = sd_rd_q;
    assign sd_wr         = sd_wr_q;
    assign sd_addr       = sd_addr_q;
    assign rd_byte_valid = rd_byte_valid_q;
    assign rd_byte       = rd_byte_q;

endmodule
